// File: rtl/ps2_paddle_ctrl_pkg.sv
// Shared PS/2 set-2 constants and frame helpers for the paddle keyboard front end.
package ps2_paddle_ctrl_pkg;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] KEY_UP   = 8'h75;
  localparam logic [7:0] KEY_DN   = 8'h72;
  localparam logic [7:0] KEY_W    = 8'h1D;
  localparam logic [7:0] KEY_S    = 8'h1B;

  localparam int FRAME_BITS = 11;

  // Frame payload is {stop, parity, data[7:0]}; parity is odd over data plus parity.
  function automatic logic frame_ok(input logic [9:0] b);
    return (^b[8:0]) & b[9];
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronisers, clock glitch filter, frame FSM and watchdog.
module ps2_rx
  import ps2_paddle_ctrl_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] scan_code,
  output logic       rx_done_tick,
  output logic       frame_err_tick
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0] N_INIT = 4'(FRAME_BITS - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DPS  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  logic                  ps2c_p0, ps2c_p1;
  logic                  ps2d_p0, ps2d_p1;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  filt_lvl, filt_next, fall_edge;
  logic [1:0]            state;
  logic [3:0]            n;
  logic [9:0]            b_reg;
  logic [WD_W-1:0]       wd_cnt;

  // Stage p0/p1: two-flop synchronisers; the bus idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2c_p0 <= 1'b1;
      ps2c_p1 <= 1'b1;
      ps2d_p0 <= 1'b1;
      ps2d_p1 <= 1'b1;
    end else begin
      ps2c_p0 <= ps2c;
      ps2c_p1 <= ps2c_p0;
      ps2d_p0 <= ps2d;
      ps2d_p1 <= ps2d_p0;
    end
  end

  // Filter stage: the level only moves once FILTER_LEN samples agree.
  always_comb begin
    filt_next = filt_lvl;
    if (&filt_reg)
      filt_next = 1'b1;
    else if (~|filt_reg)
      filt_next = 1'b0;
  end

  assign fall_edge = filt_lvl & ~filt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg <= '1;
      filt_lvl <= 1'b1;
    end else begin
      filt_reg <= {filt_reg[FILTER_LEN-2:0], ps2c_p1};
      filt_lvl <= filt_next;
    end
  end

  // Frame stage: start bit in IDLE, then data, parity and stop shifted in from the MSB side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      n              <= '0;
      b_reg          <= '0;
      wd_cnt         <= '0;
      scan_code      <= '0;
      rx_done_tick   <= 1'b0;
      frame_err_tick <= 1'b0;
    end else begin
      rx_done_tick   <= 1'b0;
      frame_err_tick <= 1'b0;
      if (fall_edge || state != ST_DPS)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (fall_edge && !ps2d_p1) begin
            n     <= N_INIT;
            state <= ST_DPS;
          end
        end
        ST_DPS: begin
          if (fall_edge) begin
            b_reg <= {ps2d_p1, b_reg[9:1]};
            if (n == 4'd0)
              state <= ST_LOAD;
            else
              n <= n - 1'b1;
          end else if (wd_cnt == WD_MAX) begin
            // Device stalled mid-frame: drop what was collected.
            frame_err_tick <= 1'b1;
            b_reg          <= '0;
            state          <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state <= ST_IDLE;
          if (frame_ok(b_reg)) begin
            scan_code    <= b_reg[7:0];
            rx_done_tick <= 1'b1;
          end else begin
            frame_err_tick <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_paddle_ctrl.sv
// PS/2 keyboard paddle controller: receives set-2 codes and turns arrow / W-S keys into held btn levels.
module ps2_paddle_ctrl
  import ps2_paddle_ctrl_pkg::*;
#(
  parameter int         FILTER_LEN  = 8,
  parameter int         TIMEOUT_CYC = 5000,
  parameter logic [7:0] CODE_UP     = KEY_UP,
  parameter logic [7:0] CODE_DN     = KEY_DN,
  parameter logic [7:0] CODE_ALT_UP = KEY_W,
  parameter logic [7:0] CODE_ALT_DN = KEY_S
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [1:0] btn,
  output logic [7:0] scan_code,
  output logic       rx_done_tick,
  output logic       frame_err_tick
);

  logic brk, ext;

  ps2_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2c           (ps2c),
    .ps2d           (ps2d),
    .scan_code      (scan_code),
    .rx_done_tick   (rx_done_tick),
    .frame_err_tick (frame_err_tick)
  );

  // Decode stage: prefixes arm brk/ext for exactly the next non-prefix byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn <= 2'b00;
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (rx_done_tick) begin
      if (scan_code == CODE_BRK) begin
        brk <= 1'b1;
      end else if (scan_code == CODE_EXT) begin
        ext <= 1'b1;
      end else begin
        if (ext) begin
          if (scan_code == CODE_UP) btn[1] <= ~brk;
          if (scan_code == CODE_DN) btn[0] <= ~brk;
        end else begin
          if (scan_code == CODE_ALT_UP) btn[1] <= ~brk;
          if (scan_code == CODE_ALT_DN) btn[0] <= ~brk;
        end
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end else if (frame_err_tick) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Directed bench for ps2_paddle_ctrl: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_paddle_ctrl;

  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2c;
  logic       ps2d;
  logic [1:0] btn;
  logic [7:0] scan_code;
  logic       rx_done_tick;
  logic       frame_err_tick;

  int n_checks = 0;
  int n_errors = 0;
  int rx_cnt   = 0;
  int err_cnt  = 0;

  ps2_paddle_ctrl #(
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ps2c           (ps2c),
    .ps2d           (ps2d),
    .btn            (btn),
    .scan_code      (scan_code),
    .rx_done_tick   (rx_done_tick),
    .frame_err_tick (frame_err_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick)   rx_cnt++;
    if (frame_err_tick) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    cycles(10);
    ps2c = 1'b0;
    cycles(20);
    ps2c = 1'b1;
    cycles(10);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par);
    logic par;
    par = ~(^data) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    send_bit(1'b1);
    ps2d = 1'b1;
    cycles(30);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    ps2c    = 1'b1;
    ps2d    = 1'b1;
    cycles(5);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(20);
    @(negedge clk);
    check("reset_btn", 32'(btn), 32'h0);
    check("reset_scan", 32'(scan_code), 32'h0);
    check("reset_rx_tick", 32'(rx_done_tick), 32'h0);
    check("reset_err_tick", 32'(frame_err_tick), 32'h0);

    // Extended up make
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("up_make_rx_cnt", 32'(rx_cnt), 32'd2);
    check("up_make_scan", 32'(scan_code), 32'h75);
    check("up_make_btn", 32'(btn), 32'h2);

    // Extended up break
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("up_break_btn", 32'(btn), 32'h0);
    check("up_break_rx_cnt", 32'(rx_cnt), 32'd5);

    // S then W make, then S break
    send_frame(8'h1B, 1'b0);
    check("s_make_btn", 32'(btn), 32'h1);
    send_frame(8'h1D, 1'b0);
    check("ws_make_btn", 32'(btn), 32'h3);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1B, 1'b0);
    check("s_break_btn", 32'(btn), 32'h2);
    check("s_break_scan", 32'(scan_code), 32'h1B);
    check("s_break_rx_cnt", 32'(rx_cnt), 32'd9);

    // Parity error after a break prefix: brk must be cleared
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b1);
    check("par_err_cnt", 32'(err_cnt), 32'd1);
    check("par_err_rx_cnt", 32'(rx_cnt), 32'd10);
    check("par_err_scan", 32'(scan_code), 32'hF0);
    check("par_err_btn", 32'(btn), 32'h2);
    send_frame(8'h1B, 1'b0);
    check("post_err_make_btn", 32'(btn), 32'h3);

    // Truncated frame then watchdog expiry
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2d = 1'b1;
    cycles(TMO + 50);
    @(negedge clk);
    check("timeout_err_cnt", 32'(err_cnt), 32'd2);
    check("timeout_rx_cnt", 32'(rx_cnt), 32'd11);
    send_frame(8'h72, 1'b0);
    check("after_timeout_scan", 32'(scan_code), 32'h72);
    check("after_timeout_rx_cnt", 32'(rx_cnt), 32'd12);
    check("after_timeout_btn", 32'(btn), 32'h3);

    // Short glitch on ps2c with data low must not start a frame
    ps2d = 1'b0;
    cycles(5);
    ps2c = 1'b0;
    cycles(3);
    ps2c = 1'b1;
    cycles(5);
    ps2d = 1'b1;
    cycles(TMO + 100);
    @(negedge clk);
    check("glitch_err_cnt", 32'(err_cnt), 32'd2);
    check("glitch_rx_cnt", 32'(rx_cnt), 32'd12);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1B, 1'b0);
    check("after_glitch_btn", 32'(btn), 32'h2);

    // Reset in the middle of a frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_btn", 32'(btn), 32'h0);
    check("midreset_scan", 32'(scan_code), 32'h0);
    cycles(3);
    @(negedge clk);
    reset_n = 1'b1;
    ps2d    = 1'b1;
    cycles(50);
    send_frame(8'h1D, 1'b0);
    check("after_reset_btn", 32'(btn), 32'h2);
    check("after_reset_scan", 32'(scan_code), 32'h1D);
    check("after_reset_rx_cnt", 32'(rx_cnt), 32'd15);
    check("after_reset_err_cnt", 32'(err_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_paddle_ctrl.md
Name: ps2_paddle_ctrl

Overview:
- PS/2 keyboard front end, directly upstream of the pong top level.
- Receives PS/2 device-to-host frames and decodes set-2 make, break and extended codes.
- Drives level-held paddle controls btn[1:0] in place of debounced push buttons.
- Also exposes raw scan codes and tick strobes for the text overlay and debug.

Parameters:
- FILTER_LEN, 8: number of consecutive equal samples required before the filtered ps2c level changes.
- TIMEOUT_CYC, 5000: clk cycles allowed between PS/2 clock falling edges inside a frame (100 us at 50 MHz) before the frame is aborted.
- CODE_UP, 8'h75: extended (E0-prefixed) scan code for the up arrow.
- CODE_DN, 8'h72: extended scan code for the down arrow.
- CODE_ALT_UP, 8'h1D: non-extended scan code for W.
- CODE_ALT_DN, 8'h1B: non-extended scan code for S.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2c  in  1  PS/2 clock, asynchronous to clk.
- ps2d  in  1  PS/2 data, asynchronous to clk.
- btn  out  2  [1] = paddle up held, [0] = paddle down held.
- scan_code  out  8  last valid received byte.
- rx_done_tick  out  1  one-cycle pulse when scan_code updates.
- frame_err_tick  out  1  one-cycle pulse on parity, stop-bit or timeout error.

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, FSM in IDLE, shift register 0, brk/ext flags 0. The filter shift register and the filtered clock level reset to 1, so the idle bus is not read as an edge.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-flop synchroniser.
  - Synchronised ps2c feeds a FILTER_LEN-bit shift register. The filtered level goes 1 when the register is all ones and 0 when it is all zeros; otherwise it holds.
  - fall_edge is a single-cycle pulse when the filtered level goes 1 to 0.
- Receive FSM:
  - IDLE: on fall_edge with ps2d=0 (start bit), go to DPS with bit counter n=9. A fall_edge with ps2d=1 is ignored.
  - DPS: on each fall_edge, shift ps2d into a 10-bit register from the MSB side (data LSB first, then parity, then stop). If n=0 at that edge, go to LOAD; otherwise decrement n.
  - LOAD: lasts exactly one cycle, then return to IDLE.
    - If the parity is odd across the 8 data bits plus the parity bit, and the stop bit is 1: scan_code <= data and rx_done_tick=1.
    - Otherwise: frame_err_tick=1 and scan_code holds.
  - Timeout: the watchdog counter clears on every fall_edge and counts while in DPS. When it reaches TIMEOUT_CYC-1: frame_err_tick=1, return to IDLE, discard the partial frame.
- Latency: rx_done_tick asserts 2 clk cycles after the fall_edge that samples the stop bit.
- Decoder (acts on rx_done_tick):
  - 8'hF0: set brk.
  - 8'hE0: set ext.
  - Any other code: if it matches a key, that btn bit <= ~brk; the arrow keys require ext=1, W/S require ext=0. Then clear brk and ext, whether or not the code matched.
  - A frame error clears brk and ext; btn holds.
- Up and down held together drive btn=2'b11; the consumer resolves the conflict. Typematic repeat makes codes (no break) leave btn unchanged at 1.
- A reset during a frame aborts it immediately. The next start bit is accepted normally.

Decomposition:
- Shared package holds the PS/2 constants: F0/E0 prefixes, the four key codes, and the frame bit count of 11.
- One natural sub-module, ps2_rx: synchronisers, filter, receive FSM and watchdog. It outputs scan_code, rx_done_tick and frame_err_tick.
- The decoder and btn registers stay in ps2_paddle_ctrl.

Test Plan:
- Frame E0, then frame 75 (valid parity) -> two rx_done_ticks; scan_code=8'h75; btn=2'b10.
- Then E0, F0, 75 -> btn=2'b00; brk and ext cleared.
- 1B make, then 1D make -> btn=2'b11. Then F0, 1B -> btn=2'b10.
- Frame 8'h1D with the parity bit inverted -> frame_err_tick=1, no rx_done_tick, btn unchanged.
- Start bit plus 4 data bits, then ps2c held high for TIMEOUT_CYC cycles -> frame_err_tick; the next full frame 8'h72 decodes correctly (scan_code=8'h72).
- 3-cycle glitch low on ps2c while in IDLE -> no state change. Assert reset_n=0 mid-frame -> outputs 0 immediately, and the following frame is received cleanly.
